// File: rtl/pll_supervisor_pkg.sv
// Shared state encodings, default parameter constants and helpers for the
// PLL lock supervisor.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_RESTART   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRY     = 3;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Retry count as reported on the 4-bit debug port, saturating at 15.
  function automatic logic [3:0] sat_retry(input int unsigned v);
    if (v > 15) return 4'hF;
    return 4'(v);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the PLL-init lock flag into the CLKIN domain.
module pll_lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLKIN,
  input  logic I_RST,
  input  logic I_ASYNC,
  output logic O_SYNC
);

  localparam int unsigned N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge CLKIN) begin
    if (I_RST) sync_q <= '0;
    else       sync_q <= {sync_q[N-2:0], I_ASYNC};
  end

  assign O_SYNC = sync_q[N-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises PLL lock: pulses the init sequencer reset, qualifies lock stability,
// gates the downstream reset, retries on timeout or lock loss, and latches FAULT.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic       CLKIN,
  input  logic       I_RST,
  input  logic       I_LOCK,
  output logic       O_INIT_RST,
  output logic       O_RST,
  output logic       O_READY,
  output logic       O_FAULT,
  output logic [3:0] O_RETRY_CNT,
  output logic [2:0] O_STATE
);

  localparam int unsigned RCNT_W = $clog2(RST_CYCLES) + 1;
  localparam int unsigned TCNT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned SCNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned RTRY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [RCNT_W-1:0] R_LAST    = RCNT_W'(RST_CYCLES - 1);
  localparam logic [TCNT_W-1:0] T_LAST    = TCNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [SCNT_W-1:0] S_LAST    = SCNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RETRY_MAX = RTRY_W'(MAX_RETRY);

  logic lock_s;

  pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLKIN  (CLKIN),
    .I_RST  (I_RST),
    .I_ASYNC(I_LOCK),
    .O_SYNC (lock_s)
  );

  pll_state_e        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic              retry_ev;

  logic       init_rst_q, rst_q, ready_q, fault_q;
  logic [3:0] retry_out_q;
  logic [2:0] state_out_q;

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    tcnt_d   = tcnt_q;
    scnt_d   = scnt_q;
    retry_d  = retry_q;
    retry_ev = 1'b0;
    unique case (state_q)
      ST_RESTART: begin
        if (rcnt_q == R_LAST) begin
          state_d = ST_WAIT_LOCK;
          rcnt_d  = '0;
          tcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (tcnt_q == T_LAST) begin
          retry_ev = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (lock_s) begin
            state_d = ST_STABLE;
            scnt_d  = '0;
          end
        end
      end
      ST_STABLE: begin
        // Timeout is tested first so it wins over a coincident completion.
        if (tcnt_q == T_LAST) begin
          retry_ev = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (!lock_s)               state_d = ST_WAIT_LOCK;
          else if (scnt_q == S_LAST) state_d = ST_RUN;
          else                       scnt_d  = scnt_q + 1'b1;
        end
      end
      ST_RUN:   if (!lock_s) retry_ev = 1'b1;
      ST_FAULT: ;
      default:  state_d = ST_RESTART;
    endcase

    if (retry_ev) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        rcnt_d  = '0;
        state_d = ST_RESTART;
      end else begin
        state_d = ST_FAULT;
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLKIN) begin
    if (I_RST) begin
      state_q     <= ST_RESTART;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      scnt_q      <= '0;
      retry_q     <= '0;
      init_rst_q  <= 1'b1;
      rst_q       <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_out_q <= '0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      retry_q     <= retry_d;
      init_rst_q  <= (state_d == ST_RESTART) || (state_d == ST_FAULT);
      rst_q       <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
      retry_out_q <= sat_retry(32'(retry_d));
      state_out_q <= state_d;
    end
  end

  assign O_INIT_RST  = init_rst_q;
  assign O_RST       = rst_q;
  assign O_READY     = ready_q;
  assign O_FAULT     = fault_q;
  assign O_RETRY_CNT = retry_out_q;
  assign O_STATE     = state_out_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: timestamp-based reference model
// compared every cycle, plus directed scenarios with hand-derived edge counts.
module tb_pll_lock_supervisor;

  localparam int unsigned RST = 16;
  localparam int unsigned LT  = 100;
  localparam int unsigned SC  = 8;
  localparam int unsigned MR  = 3;
  localparam int unsigned SS  = 2;

  localparam int P_RESTART = 0;
  localparam int P_WAIT    = 1;
  localparam int P_STABLE  = 2;
  localparam int P_RUN     = 3;
  localparam int P_FAULT   = 4;

  logic       CLKIN  = 1'b0;
  logic       I_RST  = 1'b1;
  logic       I_LOCK = 1'b0;
  logic       O_INIT_RST, O_RST, O_READY, O_FAULT;
  logic [3:0] O_RETRY_CNT;
  logic [2:0] O_STATE;

  always #5 CLKIN = ~CLKIN;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRY    (MR),
    .SYNC_STAGES  (SS)
  ) dut (
    .CLKIN      (CLKIN),
    .I_RST      (I_RST),
    .I_LOCK     (I_LOCK),
    .O_INIT_RST (O_INIT_RST),
    .O_RST      (O_RST),
    .O_READY    (O_READY),
    .O_FAULT    (O_FAULT),
    .O_RETRY_CNT(O_RETRY_CNT),
    .O_STATE    (O_STATE)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phases with absolute deadlines on an edge counter.
  int now = 0;
  int m_phase = P_RESTART;
  int restart_end = 0;
  int deadline = 0;
  int stable_due = 0;
  int m_retries = 0;
  bit m_valid = 1'b0;
  bit lpipe[$];

  always @(posedge CLKIN) begin
    bit ls;
    bit ev;
    now++;
    if (I_RST) begin
      m_phase     = P_RESTART;
      restart_end = now + RST;
      m_retries   = 0;
      lpipe.delete();
      for (int i = 0; i < SS; i++) lpipe.push_back(1'b0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      ls = lpipe[SS-1];
      void'(lpipe.pop_back());
      lpipe.push_front(I_LOCK);
      ev = 1'b0;
      case (m_phase)
        P_RESTART: if (now == restart_end) begin
          m_phase  = P_WAIT;
          deadline = now + LT;
        end
        P_WAIT, P_STABLE: begin
          if (now == deadline) ev = 1'b1;
          else if (m_phase == P_WAIT) begin
            if (ls) begin
              m_phase    = P_STABLE;
              stable_due = now + SC;
            end
          end
          else if (!ls) m_phase = P_WAIT;
          else if (now == stable_due) m_phase = P_RUN;
        end
        P_RUN: if (!ls) ev = 1'b1;
        default: ;
      endcase
      if (ev) begin
        if (m_retries < MR) begin
          m_retries++;
          m_phase     = P_RESTART;
          restart_end = now + RST;
        end else begin
          m_phase = P_FAULT;
        end
      end
    end
  end

  always @(negedge CLKIN) begin
    if (m_valid) begin
      chk("m_init_rst", O_INIT_RST, (m_phase == P_RESTART || m_phase == P_FAULT));
      chk("m_rst", O_RST, (m_phase != P_RUN));
      chk("m_ready", O_READY, (m_phase == P_RUN));
      chk("m_fault", O_FAULT, (m_phase == P_FAULT));
      chk("m_retry_cnt", O_RETRY_CNT, (m_retries > 15) ? 15 : m_retries);
      chk("m_state", O_STATE, m_phase);
    end
  end

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic do_reset(input logic l);
    I_RST  = 1'b1;
    I_LOCK = l;
    repeat (3) tick();
    I_RST = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first_init_low, first_ready, rst_edge, fault_edge;
    int rises, width, lock_at;
    logic prev_init;
    int lock_ats[2]  = '{103, 104};
    int exp_ready[2] = '{115, -1};
    int exp_retry[2] = '{0, 1};
    int len;

    I_RST  = 1'b1;
    I_LOCK = 1'b0;
    repeat (4) tick();
    chk("reset_init_rst", O_INIT_RST, 1);
    chk("reset_rst", O_RST, 1);
    chk("reset_ready", O_READY, 0);
    chk("reset_fault", O_FAULT, 0);
    chk("reset_retry", O_RETRY_CNT, 0);
    chk("reset_state", O_STATE, 0);

    // Clean lock-up with lock held high.
    do_reset(1'b1);
    first_init_low = -1;
    first_ready    = -1;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (first_init_low < 0 && !O_INIT_RST) first_init_low = e + 1;
      if (first_ready < 0 && O_READY) begin
        first_ready = e + 1;
        chk("rst_falls_with_ready", O_RST, 0);
      end
    end
    chk("init_pulse_edges", first_init_low, 16);
    chk("ready_edge", first_ready, 25);
    chk("clean_retry_cnt", O_RETRY_CNT, 0);

    // Loss of lock while running.
    I_LOCK   = 1'b0;
    rst_edge = -1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (rst_edge < 0 && O_RST) begin
        rst_edge = e + 1;
        chk("ready_falls_with_rst", O_READY, 0);
        chk("restart_on_loss", O_INIT_RST, 1);
        chk("retry_after_loss", O_RETRY_CNT, 1);
      end
    end
    chk("loss_latency", rst_edge, SS + 1);
    I_LOCK = 1'b1;
    repeat (60) tick();

    // Lock never arrives: retries exhaust into FAULT.
    do_reset(1'b0);
    prev_init  = 1'b1;
    rises      = 0;
    width      = 0;
    fault_edge = -1;
    for (int e = 0; e < 600; e++) begin
      tick();
      if (O_INIT_RST && !prev_init && !O_FAULT) begin
        rises++;
        width = 0;
      end
      if (O_INIT_RST) width++;
      if (!O_INIT_RST && prev_init && rises > 0) chk("retry_pulse_width", width, RST);
      if (fault_edge < 0 && O_FAULT) fault_edge = e + 1;
      prev_init = O_INIT_RST;
    end
    chk("retry_pulses", rises, 3);
    chk("fault_edge", fault_edge, 464);
    chk("fault_retry_cnt", O_RETRY_CNT, 3);
    I_LOCK = 1'b1;
    repeat (50) tick();
    chk("fault_sticky", O_FAULT, 1);
    chk("fault_state", O_STATE, 4);
    chk("fault_init_rst", O_INIT_RST, 1);
    chk("fault_rst", O_RST, 1);

    // One-cycle lock drop in STABLE at stable count 5.
    do_reset(1'b1);
    first_ready = -1;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (e == 19) I_LOCK = 1'b0;
      if (e == 20) I_LOCK = 1'b1;
      if (e == 22) chk("drop_back_to_wait", O_STATE, 1);
      if (first_ready < 0 && O_READY) first_ready = e + 1;
    end
    chk("drop_ready_edge", first_ready, 32);
    chk("drop_no_retry", O_RETRY_CNT, 0);

    // Timeout one cycle after vs. coincident with STABLE completion.
    for (int c = 0; c < 2; c++) begin
      lock_at = lock_ats[c];
      do_reset(1'b0);
      first_ready = -1;
      for (int e = 0; e < 130; e++) begin
        tick();
        if (e == lock_at) I_LOCK = 1'b1;
        if (first_ready < 0 && O_READY) first_ready = e + 1;
        if (e == 115) chk("edge_retry_cnt", O_RETRY_CNT, exp_retry[c]);
      end
      chk("edge_ready", first_ready, exp_ready[c]);
    end

    // Single-cycle reset while in STABLE.
    do_reset(1'b1);
    first_ready = -1;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (e == 18) begin
        chk("pre_reset_stable", O_STATE, 2);
        I_RST = 1'b1;
      end
      if (e == 19) begin
        chk("midrst_init_rst", O_INIT_RST, 1);
        chk("midrst_rst", O_RST, 1);
        chk("midrst_ready", O_READY, 0);
        chk("midrst_fault", O_FAULT, 0);
        chk("midrst_retry", O_RETRY_CNT, 0);
        chk("midrst_state", O_STATE, 0);
        I_RST = 1'b0;
      end
      if (first_ready < 0 && O_READY) first_ready = e + 1;
    end
    chk("midrst_ready_edge", first_ready, 45);

    // Randomized lock behaviour with occasional resets.
    for (int t = 0; t < 40; t++) begin
      do_reset(logic'($urandom_range(0, 1)));
      for (int s = 0; s < 12; s++) begin
        len    = $urandom_range(1, 60);
        I_LOCK = logic'($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 30) == 0) begin
          I_RST = 1'b1;
          tick();
          I_RST = 1'b0;
        end
        repeat (len) tick();
      end
    end

    @(negedge CLKIN);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL-init reset pulse width, in CLKIN cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed from leaving RESTART to reaching RUN.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before releasing the downstream reset.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of restarts allowed before FAULT.
REQ-005 SHALL have parameter SYNC_STAGES, default 2: flop count of the lock synchronizer, minimum 2.
REQ-006 SHALL have port CLKIN, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port I_RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port I_LOCK, input, 1 bit: lock qualified by the upstream PLL-init sequencer (its O_LOCK); asynchronous to CLKIN.
REQ-009 SHALL have port O_INIT_RST, output, 1 bit: drives the PLL-init sequencer's I_RST to restart calibration.
REQ-010 SHALL have port O_RST, output, 1 bit: active-high reset to the consumers of the PLL clocks.
REQ-011 SHALL have port O_READY, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port O_FAULT, output, 1 bit: high only in state FAULT.
REQ-013 SHALL have port O_RETRY_CNT, output, 4 bits: restarts since reset, saturating at 15.
REQ-014 SHALL have port O_STATE, output, 3 bits: current state encoding, for debug.

Function
REQ-015 SHALL pass I_LOCK through SYNC_STAGES flops to form lock_s; all decisions use lock_s only.
REQ-016 SHALL implement states RESTART=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
REQ-017 In RESTART: O_INIT_RST=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK; clear the timeout counter on exit.
REQ-018 In WAIT_LOCK: when lock_s=1, go to STABLE with the stable counter cleared.
REQ-019 In STABLE: increment the stable counter while lock_s=1; when lock_s=0, return to WAIT_LOCK without clearing the timeout counter.
REQ-020 In STABLE: when the stable count reaches STABLE_CYCLES-1 with lock_s=1, go to RUN on the next edge.
REQ-021 In WAIT_LOCK and STABLE: the timeout counter increments every cycle; when it reaches LOCK_TIMEOUT-1, a timeout occurs.
REQ-022 In RUN: when lock_s=0 (loss of lock), a retry event occurs.
REQ-023 On a retry event (timeout, or loss of lock in RUN): if retry_cnt<MAX_RETRY, increment retry_cnt and go to RESTART; otherwise go to FAULT.
REQ-024 Timeout SHALL take priority over a coincident STABLE completion.
REQ-025 FAULT SHALL be terminal until I_RST; in FAULT, O_INIT_RST=1 and O_RST=1.
REQ-026 All outputs SHALL be registered.
REQ-027 O_RST SHALL be 1 in every state except RUN.
REQ-028 O_RST SHALL rise on the edge following the first lock_s=0 sample in RUN.
REQ-029 O_READY SHALL fall on the same edge that O_RST rises.
REQ-030 Counter widths SHALL be $clog2 of the respective parameter plus 1; counters SHALL NOT wrap.

Reset
REQ-031 While I_RST=1: state=RESTART, all counters 0, synchronizer flops 0, O_INIT_RST=1, O_RST=1, O_READY=0, O_FAULT=0, O_RETRY_CNT=0, O_STATE=0.
REQ-032 The RESTART pulse count SHALL begin on the first edge with I_RST=0.
REQ-033 Asserting I_RST mid-operation (any state) SHALL take effect on the next edge.

Structure
REQ-034 State encodings and default parameter constants SHALL reside in shared package pll_supervisor_pkg.
REQ-035 The synchronizer SHALL be sub-module pll_lock_sync (parameter SYNC_STAGES, ports CLKIN, I_RST, I_ASYNC, O_SYNC).

Verification
REQ-036 Release reset with I_LOCK=1 constantly, RST_CYCLES=16, STABLE_CYCLES=8 -> O_INIT_RST high 16 cycles; O_RST falls and O_READY rises at a fixed, checked cycle; O_RETRY_CNT=0.
REQ-037 Hold I_LOCK=0, LOCK_TIMEOUT=100, MAX_RETRY=3 -> exactly 3 restart pulses, then O_FAULT=1 and O_RETRY_CNT=3; FAULT persists until I_RST.
REQ-038 In STABLE, drop I_LOCK for 1 cycle at stable count 5 -> return to WAIT_LOCK; RUN reached only after 8 further consecutive lock cycles; no retry.
REQ-039 In RUN, drop I_LOCK -> O_RST=1 and O_READY=0 within SYNC_STAGES+1 cycles; RESTART pulse issued; O_RETRY_CNT=1.
REQ-040 Timeout expiry coincident with STABLE completion -> RESTART taken, not RUN.
REQ-041 Assert I_RST for 1 cycle while in STABLE -> all outputs return to their reset values on the next edge.
